// File: rtl/normal_flit_scheduler.sv
// Normal-flit scheduler: round-robin pick of local/forwarded flits, routing lookup with timeout,
// and hand-off to the flit generator with drop accounting.
package types;
  typedef logic [7:0] node_id_t;

  typedef struct packed {
    node_id_t    dst_id;
    node_id_t    src_id;
    logic [7:0]  vc_type;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [31:0] payload;
  } flit_t;
endpackage

module normal_flit_scheduler #(
  parameter int unsigned LOOKUP_TIMEOUT = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 nocclk,
  input  logic                 rst_n,
  input  types::flit_t         local_flit,
  input  logic                 local_valid,
  output logic                 local_ready,
  input  types::flit_t         fwd_flit,
  input  logic                 fwd_valid,
  output logic                 fwd_ready,
  input  types::node_id_t      this_node_id,
  output logic                 lookup_req,
  output types::node_id_t      lookup_dst,
  input  logic                 lookup_done,
  input  logic                 lookup_hit,
  input  types::node_id_t      lookup_next,
  output types::flit_t         gen_flit,
  output logic                 gen_flit_valid,
  output types::node_id_t      gen_next_destination,
  output logic                 gen_next_destination_valid,
  output logic                 gen_is_destination_self,
  input  logic                 gen_flit_out_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     drop_cnt
);

  typedef enum logic [1:0] {StIdle, StLookup, StSend} state_e;

  state_e          state_q, state_d;
  logic            prio_q;
  logic [7:0]      tmo_q;
  types::flit_t    flit_q;
  types::node_id_t next_hop_q;
  logic            nh_valid_q;
  logic            self_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic            grant_local, grant_fwd, accept;
  types::flit_t    sel_flit;
  logic            sel_is_self, lookup_expired, drop;

  // prio_q = 1 means the forward source is preferred when both are valid.
  always_comb begin
    grant_local    = local_valid & (~fwd_valid | ~prio_q);
    grant_fwd      = fwd_valid & (~local_valid | prio_q);
    sel_flit       = grant_fwd ? fwd_flit : local_flit;
    sel_is_self    = (sel_flit.hdr.dst_id == this_node_id);
    accept         = (state_q == StIdle) & (grant_local | grant_fwd);
    lookup_expired = (tmo_q >= 8'(LOOKUP_TIMEOUT - 1));
    drop           = (state_q == StSend) & ~gen_flit_out_valid;
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = sel_is_self ? StSend : StLookup;
      StLookup: if (lookup_done || lookup_expired) state_d = StSend;
      StSend:   if (!gen_flit_out_valid || tx_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Ready is gated by rst_n so it stays low while reset is held and valids are up.
  always_comb begin
    local_ready    = rst_n & (state_q == StIdle) & grant_local;
    fwd_ready      = rst_n & (state_q == StIdle) & grant_fwd;
    lookup_req     = (state_q == StLookup);
    gen_flit_valid = (state_q == StSend);
    busy           = (state_q != StIdle);
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      tmo_q      <= 8'd0;
      flit_q     <= '0;
      next_hop_q <= '0;
      nh_valid_q <= 1'b0;
      self_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (accept) begin
        prio_q     <= grant_local;
        flit_q     <= sel_flit;
        self_q     <= sel_is_self;
        nh_valid_q <= 1'b0;
        tmo_q      <= 8'd0;
      end else if (state_q == StLookup) begin
        tmo_q <= tmo_q + 8'd1;
        if (lookup_done) begin
          nh_valid_q <= lookup_hit;
          if (lookup_hit) next_hop_q <= lookup_next;
        end
      end
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign lookup_dst                 = flit_q.hdr.dst_id;
  assign gen_flit                   = flit_q;
  assign gen_next_destination       = next_hop_q;
  assign gen_next_destination_valid = nh_valid_q;
  assign gen_is_destination_self    = self_q;
  assign drop_cnt                   = drop_cnt_q;

endmodule

// File: doc/normal_flit_scheduler.md
NORMAL_FLIT_SCHEDULER -- requirements
Module: normal_flit_scheduler

Interface
REQ-001 Parameter LOOKUP_TIMEOUT, default 16, max cycles in LOOKUP before the lookup is treated as a miss (legal range 1..255).
REQ-002 Parameter CNT_W, default 16, width of the drop counter.
REQ-003 nocclk  in  1  block clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 local_flit  in  types::flit_t  locally injected flit.
REQ-006 local_valid / local_ready  in / out  1  local source handshake.
REQ-007 fwd_flit  in  types::flit_t  flit forwarded from the receive path.
REQ-008 fwd_valid / fwd_ready  in / out  1  forward source handshake.
REQ-009 this_node_id  in  types::node_id_t  own node ID.
REQ-010 lookup_req / lookup_dst  out  1 / types::node_id_t  routing-table query and queried destination.
REQ-011 lookup_done / lookup_hit / lookup_next  in  1 / 1 / types::node_id_t  lookup response, hit flag and next hop.
REQ-012 gen_flit / gen_flit_valid  out  types::flit_t / 1  flit and valid to the normal flit generator.
REQ-013 gen_next_destination / gen_next_destination_valid / gen_is_destination_self  out  types::node_id_t / 1 / 1  generator routing inputs.
REQ-014 gen_flit_out_valid  in  1  generator output valid (low while gen_flit_valid is high means drop).
REQ-015 tx_ready  in  1  downstream link accepts the generator output this cycle.
REQ-016 busy  out  1  state is not IDLE.
REQ-017 drop_cnt  out  CNT_W  saturating count of dropped flits.

Function
REQ-018 States IDLE, LOOKUP, SEND; encoding free.
REQ-019 IDLE: local_ready and fwd_ready are combinational; at most one is high per cycle, only that of the granted source, and both are low outside IDLE.
REQ-020 Arbitration is round-robin with a 1-bit priority pointer (0 = local first); a lone valid source is granted regardless of the pointer.
REQ-021 The pointer flips to the non-granted source only on an accepted handshake (valid and ready both high).
REQ-022 On accept, the flit is captured into an internal register; gen_flit always shows this register.
REQ-023 If the captured header dst_id equals this_node_id: next state SEND, with gen_is_destination_self=1 and gen_next_destination_valid=0.
REQ-024 Otherwise: next state LOOKUP, lookup_dst is set to the captured dst_id, and the timeout counter is cleared.
REQ-025 LOOKUP: lookup_req=1 every cycle while in LOOKUP; the timeout counter increments each cycle.
REQ-026 lookup_done with lookup_hit=1: register lookup_next as the next hop, set next_destination_valid=1, and go to SEND.
REQ-027 lookup_done with lookup_hit=0, or counter reaching LOOKUP_TIMEOUT without lookup_done: next_destination_valid=0, go to SEND. If both happen in the same cycle, lookup_done wins.
REQ-028 SEND: gen_flit_valid=1; the registered next hop, valid flag and self flag are held stable.
REQ-029 SEND with gen_flit_out_valid=1 and tx_ready=1: go to IDLE (flit delivered).
REQ-030 SEND with gen_flit_out_valid=1 and tx_ready=0: stay in SEND; all gen_* outputs are held unchanged.
REQ-031 SEND with gen_flit_out_valid=0: drop the flit, increment drop_cnt (saturating at all-ones), and go to IDLE.
REQ-032 Minimum latency from accept to gen_flit_valid: 1 cycle for the self path; 2 cycles for a lookup answered in its first LOOKUP cycle.
REQ-033 Throughput: one flit per state round trip; no new source is accepted in the cycle the scheduler leaves SEND.
REQ-034 lookup_done outside LOOKUP is ignored.

Reset
REQ-035 On rst_n low, asynchronously and at any time including mid-operation, the scheduler SHALL enter IDLE with pointer=0, timeout counter=0, drop_cnt=0, captured flit=0, and next hop=0.
REQ-036 During reset, all outputs SHALL be 0: ready signals, lookup_req, gen_flit_valid, gen_next_destination_valid, gen_is_destination_self and busy.
REQ-037 A flit in flight at reset assertion is discarded without a drop count.

Verification
REQ-038 Both sources valid for 4 accepts, tx_ready=1, lookups hit -> grant order local, fwd, local, fwd.
REQ-039 fwd flit with dst_id=this_node_id -> no lookup_req, gen_is_destination_self=1, and gen_flit_valid high 1 cycle after accept.
REQ-040 LOOKUP_TIMEOUT=4 and no lookup_done -> lookup_req high exactly 4 cycles, then SEND with gen_next_destination_valid=0.
REQ-041 lookup hit with lookup_next=0x05, tx_ready low for 3 cycles -> gen_flit and gen_next_destination=0x05 stable for 4 cycles, then IDLE.
REQ-042 Lookup miss with gen_flit_out_valid held 0 -> drop_cnt goes 0->1 and state returns to IDLE next cycle; with CNT_W=2 and 5 drops, drop_cnt=3.
REQ-043 rst_n pulsed low while in LOOKUP -> busy=0, lookup_req=0 and drop_cnt unchanged at 0 immediately, with no clock edge required.
